rv_mdu_seq: RTL



---
 rtl/rv_mdu_pkg.sv | 25 ++
 rtl/rv_mdu_seq_if.sv | 29 ++
 rtl/rv_mdu_addsub.sv | 20 ++
 rtl/rv_mdu_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rv_mdu_pkg.sv
`default_nettype none
// ============================================================================
// rv_mdu_pkg : funct3 operation codes and FSM encoding for rv_mdu_seq
// Revision   : 1.0
// ============================================================================
package rv_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/rv_mdu_seq_if.sv
`default_nettype none
// ============================================================================
// rv_mdu_seq_if : request/response bundle between execute stage and the MDU
// Revision      : 1.0
// ============================================================================
interface rv_mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic            illegal_o;

    modport master (
        output start_i, funct3_i, rs1_i, rs2_i, flush_i,
        input  busy_o, done_o, result_o, illegal_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_i, rs2_i, flush_i,
        output busy_o, done_o, result_o, illegal_o
    );
endinterface
`default_nettype wire

// File: rtl/rv_mdu_addsub.sv
`default_nettype none
// ============================================================================
// rv_mdu_addsub : W-bit adder/subtractor with carry-out (carry=1 means no borrow)
// Revision      : 1.0
// ============================================================================
module rv_mdu_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         carry
);
    logic [W-1:0] b_eff;

    assign b_eff        = sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
endmodule
`default_nettype wire

// File: rtl/rv_mdu_seq.sv
`default_nettype none
// ============================================================================
// rv_mdu_seq : iterative RV32M multiply/divide sequencer (one bit per cycle)
// Build option: define RV_MDU_DIV_EN to include the divider and its early path
// Revision    : 1.0
// ============================================================================
module rv_mdu_seq
    import rv_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    rv_mdu_seq_if.slave mdu
);
    localparam logic [XLEN-1:0] CNT_LAST = XLEN'(XLEN - 1);

    mdu_state_t        state_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;

    logic              rs1_signed, rs2_signed, sign1, sign2;
    logic [XLEN-1:0]   abs1, abs2;
    logic              early;
    logic [XLEN-1:0]   early_result;
    logic              early_illegal;

    logic [XLEN:0]     add_a, add_b, add_sum;
    logic              add_sub, add_carry;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        rs1_signed = (mdu.funct3_i != MDU_MULHU) && (mdu.funct3_i != MDU_DIVU)
                  && (mdu.funct3_i != MDU_REMU);
        rs2_signed = rs1_signed && (mdu.funct3_i != MDU_MULHSU);
    end

    assign sign1 = rs1_signed & mdu.rs1_i[XLEN-1];
    assign sign2 = rs2_signed & mdu.rs2_i[XLEN-1];
    assign abs1  = sign1 ? -mdu.rs1_i : mdu.rs1_i;
    assign abs2  = sign2 ? -mdu.rs2_i : mdu.rs2_i;

`ifdef RV_MDU_DIV_EN
    logic sign1_q;
    logic div_zero, div_ovf;

    assign div_zero = (mdu.rs2_i == '0);
    assign div_ovf  = ((mdu.funct3_i == MDU_DIV) || (mdu.funct3_i == MDU_REM))
                   && (mdu.rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (mdu.rs2_i == '1);

    always_comb begin
        early         = mdu.funct3_i[2] && (div_zero || div_ovf);
        early_illegal = 1'b0;
        if (div_zero)
            early_result = mdu.funct3_i[1] ? mdu.rs1_i : '1;
        else
            early_result = mdu.funct3_i[1] ? '0 : mdu.rs1_i;
    end

    // Division shifts {rem, next dividend bit} against the divisor; multiply adds the multiplicand.
    always_comb begin
        if (op_q[2]) begin
            add_a    = acc_q[2*XLEN-1:XLEN-1];
            add_b    = {1'b0, opnd_q};
            add_sub  = 1'b1;
            acc_next = {add_carry ? add_sum[XLEN-1:0] : add_a[XLEN-1:0],
                        acc_q[XLEN-2:0], add_carry};
        end else begin
            add_a    = {1'b0, acc_q[2*XLEN-1:XLEN]};
            add_b    = acc_q[0] ? {1'b0, opnd_q} : '0;
            add_sub  = 1'b0;
            acc_next = {add_sum, acc_q[XLEN-1:1]};
        end
    end
`else
    logic unused_carry;

    assign unused_carry  = add_carry;
    assign early         = mdu.funct3_i[2];
    assign early_result  = '0;
    assign early_illegal = 1'b1;

    always_comb begin
        add_a    = {1'b0, acc_q[2*XLEN-1:XLEN]};
        add_b    = acc_q[0] ? {1'b0, opnd_q} : '0;
        add_sub  = 1'b0;
        acc_next = {add_sum, acc_q[XLEN-1:1]};
    end
`endif

    rv_mdu_addsub #(.W(XLEN + 1)) u_addsub (
        .a     (add_a),
        .b     (add_b),
        .sub   (add_sub),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_comb begin
        prod_fix   = neg_q ? -acc_q : acc_q;
        fix_result = prod_fix[XLEN-1:0];
        case (op_q)
            MDU_MUL:                          fix_result = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
`ifdef RV_MDU_DIV_EN
            MDU_DIV, MDU_DIVU:  fix_result = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            MDU_REM, MDU_REMU:  fix_result = sign1_q ? -acc_q[2*XLEN-1:XLEN]
                                                     : acc_q[2*XLEN-1:XLEN];
`endif
            default:                          fix_result = prod_fix[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            op_q          <= MDU_MUL;
            neg_q         <= 1'b0;
            cnt_q         <= '0;
            acc_q         <= '0;
            opnd_q        <= '0;
            mdu.busy_o    <= 1'b0;
            mdu.done_o    <= 1'b0;
            mdu.result_o  <= '0;
            mdu.illegal_o <= 1'b0;
`ifdef RV_MDU_DIV_EN
            sign1_q       <= 1'b0;
`endif
        end else if (mdu.flush_i) begin
            state_q    <= IDLE;
            mdu.busy_o <= 1'b0;
            mdu.done_o <= 1'b0;
        end else begin
            mdu.done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mdu.start_i) begin
                        op_q       <= mdu.funct3_i;
                        neg_q      <= sign1 ^ sign2;
                        cnt_q      <= '0;
                        mdu.busy_o <= 1'b1;
`ifdef RV_MDU_DIV_EN
                        sign1_q    <= sign1;
`endif
                        if (early) begin
                            state_q       <= DONE;
                            mdu.done_o    <= 1'b1;
                            mdu.result_o  <= early_result;
                            mdu.illegal_o <= early_illegal;
                        end else begin
                            state_q <= CALC;
                            acc_q   <= {{XLEN{1'b0}}, abs1};
                            opnd_q  <= abs2;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + XLEN'(1);
                    if (cnt_q == CNT_LAST)
                        state_q <= FIX;
                end
                FIX: begin
                    state_q       <= DONE;
                    mdu.done_o    <= 1'b1;
                    mdu.result_o  <= fix_result;
                    mdu.illegal_o <= 1'b0;
                end
                DONE: begin
                    state_q    <= IDLE;
                    mdu.busy_o <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    mdu.busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
